// File: rtl/biriscv_ram_pkg.sv
// Shared types and helpers for the biriscv tightly-coupled RAM.
package biriscv_ram_pkg;

   typedef enum logic [0:0] {
      StInit  = 1'b0,
      StReady = 1'b1
   } ram_state_e;

   function automatic int unsigned strb_width(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/biriscv_tcm_ram_if.sv
// Fetch (A, read-only) and data (B, read/write) request/response bundle.
interface biriscv_tcm_ram_if
   import biriscv_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);

   logic                  a_req_i;
   logic [ADDR_WIDTH-1:0] a_addr_i;
   logic                  a_gnt_o;
   logic                  a_rvalid_o;
   logic [DATA_WIDTH-1:0] a_rdata_o;

   logic                  b_req_i;
   logic                  b_we_i;
   logic [ADDR_WIDTH-1:0] b_addr_i;
   logic [DATA_WIDTH-1:0] b_wdata_i;
   logic [STRB_WIDTH-1:0] b_wstrb_i;
   logic                  b_gnt_o;
   logic                  b_rvalid_o;
   logic [DATA_WIDTH-1:0] b_rdata_o;

   modport master (
      output a_req_i, a_addr_i, b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wstrb_i,
      input  a_gnt_o, a_rvalid_o, a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o
   );

   modport slave (
      input  a_req_i, a_addr_i, b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wstrb_i,
      output a_gnt_o, a_rvalid_o, a_rdata_o, b_gnt_o, b_rvalid_o, b_rdata_o
   );

endinterface

// File: rtl/biriscv_ram_rdpipe.sv
// Read response pipeline: turns a grant into a one-cycle rvalid LATENCY cycles later and
// holds the last returned data while idle.
module biriscv_ram_rdpipe #(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned WIDTH   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,   // valid the cycle after in_valid was sampled
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic v1_q;

   // First stage: remember which edges granted an access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
      end
   end

   if (LATENCY == 2) begin : g_lat2
      logic             v2_q;
      logic [WIDTH-1:0] d2_q;

      // Second stage: register data so it stays put until the next response
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) begin
               d2_q <= in_data;
            end
         end
      end

      assign out_valid = v2_q;
      assign out_data  = d2_q;
   end else begin : g_lat1
      logic [WIDTH-1:0] hold_q;

      assign out_valid = v1_q;
      assign out_data  = v1_q ? in_data : hold_q;

      // Keep the last response visible while no new one is due
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            hold_q <= '0;
         end else begin
            hold_q <= out_data;
         end
      end
   end

endmodule

// File: rtl/biriscv_tcm_ram.sv
// Dual-port TCM: port A fetch reads, port B data reads/writes with byte strobes. Optional
// zero fill after reset; same-address A/B collisions are forwarded outside the array.
module biriscv_tcm_ram
   import biriscv_ram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 14,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned INIT_ZERO    = 1,
   parameter int unsigned FORWARD      = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             init_done_o,
   biriscv_tcm_ram_if.slave bus
);

   localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);
   localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

   ram_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  fill_done_q, fill_done_d;
   logic                  init_done_q;
   logic                  init_we;

   logic                  a_gnt, b_gnt;
   logic                  port_b_en, wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] a_ram_q, b_ram_q;

   logic                  fwd_q;
   logic [DATA_WIDTH-1:0] fwd_wdata_q;
   logic [STRB_WIDTH-1:0] fwd_strb_q;
   logic [DATA_WIDTH-1:0] a_data;

   // Next state: zero one word per cycle, then spend one cycle switching to READY
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fill_done_d = fill_done_q;
      init_we     = 1'b0;
      unique case (state_q)
         StInit: begin
            if (INIT_ZERO == 0 || fill_done_q) begin
               state_d = StReady;
            end else begin
               init_we = 1'b1;
               cnt_d   = cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                  fill_done_d = 1'b1;
               end
            end
         end
         StReady: ;
         default: state_d = StInit;
      endcase
   end

   // FSM, fill counter and ready flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         fill_done_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fill_done_q <= fill_done_d;
         init_done_q <= (state_d == StReady);
      end
   end

   assign init_done_o = init_done_q;
   assign a_gnt       = bus.a_req_i & (state_q == StReady);
   assign b_gnt       = bus.b_req_i & (state_q == StReady);
   assign bus.a_gnt_o = a_gnt;
   assign bus.b_gnt_o = b_gnt;

   // Port B is shared between the zero fill and data accesses (grants are off during fill)
   always_comb begin
      port_b_en = init_we | b_gnt;
      wr_en     = init_we | (b_gnt & bus.b_we_i);
      wr_addr   = init_we ? cnt_q : bus.b_addr_i;
      wr_data   = init_we ? '0 : bus.b_wdata_i;
      wr_strb   = init_we ? '1 : bus.b_wstrb_i;
   end

   // Array port A: registered read
   always_ff @(posedge clk_i) begin
      if (a_gnt) begin
         a_ram_q <= mem[bus.a_addr_i];
      end
   end

   // Array port B: read-first, byte-lane writes
   always_ff @(posedge clk_i) begin
      if (port_b_en) begin
         b_ram_q <= mem[wr_addr];
         if (wr_en) begin
            for (int i = 0; i < int'(STRB_WIDTH); i++) begin
               if (wr_strb[i]) begin
                  mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
               end
            end
         end
      end
   end

   // Flag same-address A read / B write so the merge can happen after the array
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fwd_q <= 1'b0;
      end else begin
         fwd_q <= a_gnt & b_gnt & bus.b_we_i & (bus.a_addr_i == bus.b_addr_i);
      end
   end

   // Write data kept for the collision merge
   always_ff @(posedge clk_i) begin
      if (b_gnt) begin
         fwd_wdata_q <= bus.b_wdata_i;
         fwd_strb_q  <= bus.b_wstrb_i;
      end
   end

   // A read data: array word, or merged post-write word on a forwarded collision
   always_comb begin
      a_data = a_ram_q;
      if (FORWARD != 0 && fwd_q) begin
         for (int i = 0; i < int'(STRB_WIDTH); i++) begin
            if (fwd_strb_q[i]) begin
               a_data[8*i +: 8] = fwd_wdata_q[8*i +: 8];
            end
         end
      end
   end

   biriscv_ram_rdpipe #(
      .LATENCY (READ_LATENCY),
      .WIDTH   (DATA_WIDTH)
   ) u_rdpipe_a (
      .clk       (clk_i),
      .rst       (rst_i),
      .in_valid  (a_gnt),
      .in_data   (a_data),
      .out_valid (bus.a_rvalid_o),
      .out_data  (bus.a_rdata_o)
   );

   biriscv_ram_rdpipe #(
      .LATENCY (READ_LATENCY),
      .WIDTH   (DATA_WIDTH)
   ) u_rdpipe_b (
      .clk       (clk_i),
      .rst       (rst_i),
      .in_valid  (b_gnt),
      .in_data   (b_ram_q),
      .out_valid (bus.b_rvalid_o),
      .out_data  (bus.b_rdata_o)
   );

endmodule
